// File: rtl/decode_rf_pkg.sv
// Shared constants for the bananachine decode stage: opcode and ext field
// encodings, ALU control words, and the sequencer state type.
package bananachine_pkg;

    // Major opcodes that are not plain ALU operations
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // ALU operation codes, used both as R-type ext and as I-type op
    localparam logic [3:0] CODE_AND  = 4'b0001;
    localparam logic [3:0] CODE_OR   = 4'b0010;
    localparam logic [3:0] CODE_XOR  = 4'b0011;
    localparam logic [3:0] CODE_ADD  = 4'b0101;
    localparam logic [3:0] CODE_ADDU = 4'b0110;
    localparam logic [3:0] CODE_SUB  = 4'b1001;
    localparam logic [3:0] CODE_CMP  = 4'b1011;
    localparam logic [3:0] CODE_MOV  = 4'b1101;

    // Ext value selecting register-amount shift under OP_SHIFT
    localparam logic [3:0] EXT_LSH = 4'b0100;

    // ALU control words {category, op}
    localparam logic [5:0] CONT_NONE = 6'b000000;
    localparam logic [5:0] CONT_AND  = 6'b000001;
    localparam logic [5:0] CONT_OR   = 6'b000010;
    localparam logic [5:0] CONT_XOR  = 6'b000011;
    localparam logic [5:0] CONT_ADD  = 6'b000101;
    localparam logic [5:0] CONT_ADDU = 6'b000110;
    localparam logic [5:0] CONT_SUB  = 6'b001001;
    localparam logic [5:0] CONT_CMP  = 6'b001011;
    localparam logic [5:0] CONT_MOV  = 6'b001101;
    localparam logic [5:0] CONT_LSH  = 6'b100101;
    localparam logic [5:0] CONT_LUI  = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // True for the eight codes the ALU accepts as a basic operation
    function automatic logic is_alu_code(input logic [3:0] code);
        return code inside {CODE_AND, CODE_OR, CODE_XOR, CODE_ADD,
                            CODE_ADDU, CODE_SUB, CODE_CMP, CODE_MOV};
    endfunction

endpackage

// File: rtl/decode_rf_if.sv
// Instruction handshake, ALU operand/result bus and debug read port of the
// decode stage. The master side feeds instructions and plays the ALU.
interface decode_rf_if #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 6,
    parameter int REG_ADDR_BITS = 4
);
    logic [15:0]              inst;
    logic                     inst_valid;
    logic                     inst_ready;
    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic [ALU_CONT_BITS-1:0] alu_cont;
    logic [WIDTH-1:0]         alu_out;
    logic                     retire;
    logic                     illegal;
    logic [REG_ADDR_BITS-1:0] dbg_addr;
    logic [WIDTH-1:0]         dbg_data;

    modport master (
        output inst, inst_valid, alu_out, dbg_addr,
        input  inst_ready, alu_a, alu_b, alu_cont, retire, illegal, dbg_data
    );

    modport slave (
        input  inst, inst_valid, alu_out, dbg_addr,
        output inst_ready, alu_a, alu_b, alu_cont, retire, illegal, dbg_data
    );
endinterface

// File: rtl/decode_rf_regfile16.sv
// Sixteen-entry register file: two combinational operand reads, a
// combinational debug read, one synchronous write, synchronous clear.
module regfile16 #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr_a,
    output logic [WIDTH-1:0]     rdata_a,
    input  logic [ADDR_BITS-1:0] raddr_b,
    output logic [WIDTH-1:0]     rdata_b,
    input  logic [ADDR_BITS-1:0] dbg_addr,
    output logic [WIDTH-1:0]     dbg_data
);
    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    // Clear wins over a write in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_BITS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/decode_rf.sv
// Decode and register-file stage: latches one instruction, presents its
// operands and control word to the ALU for EXEC and WB, then writes back.
module decode_rf
    import bananachine_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 6,
    parameter int REG_ADDR_BITS = 4
) (
    input logic        clk,
    input logic        reset,
    decode_rf_if.slave bus
);
    state_t state;
    state_t state_next;
    logic [15:0] inst_q;

    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ext;
    logic [3:0] rs;
    logic [7:0] imm8;

    logic                     legal;
    logic                     writes;
    logic [ALU_CONT_BITS-1:0] cont;
    logic [WIDTH-1:0]         operand_b;
    logic [WIDTH-1:0]         rd_value;
    logic [WIDTH-1:0]         rs_value;

    assign op   = inst_q[15:12];
    assign rd   = inst_q[11:8];
    assign ext  = inst_q[7:4];
    assign rs   = inst_q[3:0];
    assign imm8 = inst_q[7:0];

    regfile16 #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (REG_ADDR_BITS)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (state == WB && writes),
        .waddr    (rd),
        .wdata    (bus.alu_out),
        .raddr_a  (rd),
        .rdata_a  (rd_value),
        .raddr_b  (rs),
        .rdata_b  (rs_value),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data)
    );

    // Sequencer state and instruction latch; the latch only loads on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            inst_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.inst_valid) begin
                inst_q <= bus.inst;
            end
        end
    end

    // Three-step sequence: accept in IDLE, one EXEC cycle, one WB cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.inst_valid) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode the latched word into control, second operand and legality
    always_comb begin
        legal     = 1'b0;
        cont      = CONT_NONE;
        operand_b = '0;
        case (op)
            OP_RTYPE: begin
                if (is_alu_code(ext)) begin
                    legal     = 1'b1;
                    cont      = {2'b00, ext};
                    operand_b = rs_value;
                end
            end
            OP_SHIFT: begin
                if (ext == EXT_LSH) begin
                    legal     = 1'b1;
                    cont      = CONT_LSH;
                    operand_b = rs_value;
                end else if (ext[3:1] == 3'b000) begin
                    legal     = 1'b1;
                    cont      = CONT_LSH;
                    operand_b = {{(WIDTH-5){ext[0]}}, ext[0], rs};
                end
            end
            OP_LUI: begin
                legal     = 1'b1;
                cont      = CONT_LUI;
                operand_b = {{(WIDTH-8){1'b0}}, imm8};
            end
            default: begin
                if (is_alu_code(op)) begin
                    legal = 1'b1;
                    cont  = {2'b00, op};
                    if (op == CODE_AND || op == CODE_OR || op == CODE_XOR) begin
                        operand_b = {{(WIDTH-8){1'b0}}, imm8};
                    end else begin
                        operand_b = {{(WIDTH-8){imm8[7]}}, imm8};
                    end
                end
            end
        endcase
    end

    assign writes = legal && (cont != CONT_CMP);

    assign bus.inst_ready = (state == IDLE);
    assign bus.alu_a      = rd_value;
    assign bus.alu_b      = operand_b;
    assign bus.alu_cont   = cont;
    assign bus.retire     = (state == WB);
    assign bus.illegal    = (state == WB) && !legal;
endmodule

// File: tb/tb_decode_rf.sv
// Self-checking bench for decode_rf: test-plan vectors from a table,
// hand-written handshake and reset sequences, then random instructions
// checked against a behavioural model. The bench also plays the ALU.
module tb_decode_rf;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [15:0] model_rf [16];

    decode_rf_if #(.WIDTH(16), .ALU_CONT_BITS(6), .REG_ADDR_BITS(4)) bus ();

    decode_rf #(.WIDTH(16), .ALU_CONT_BITS(6), .REG_ADDR_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] inst;
        logic [5:0]  cont;
        logic [15:0] a;
        logic [15:0] b;
        logic        ill;
        logic [15:0] rd_after;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: result from operands and control word
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [5:0] c);
        int sh;
        case (c)
            6'b000001: return a & b;
            6'b000010: return a | b;
            6'b000011: return a ^ b;
            6'b000101: return a + b;
            6'b000110: return a + b;
            6'b001001: return a - b;
            6'b001101: return b;
            6'b100101: begin
                sh = int'($signed(b));
                if (sh >= 0) return a << sh;
                else         return a >> (-sh);
            end
            6'b111111: return b << 8;
            default:   return 16'h0000;
        endcase
    endfunction

    assign bus.alu_out = alu_fn(bus.alu_a, bus.alu_b, bus.alu_cont);

    function automatic bit basic_code(input int code);
        return code == 1 || code == 2 || code == 3 || code == 5 ||
               code == 6 || code == 9 || code == 11 || code == 13;
    endfunction

    // Reference decode from the instruction-set rules, using the model RF
    task automatic ref_decode(input logic [15:0] word, output logic legal,
                              output logic [5:0] cont, output logic [15:0] b,
                              output logic wr);
        int op   = int'(word[15:12]);
        int ext  = int'(word[7:4]);
        int imm  = int'(word[7:0]);
        int sh5;
        legal = 1'b0;
        cont  = 6'd0;
        b     = 16'd0;
        if (op == 0 && basic_code(ext)) begin
            legal = 1'b1;
            cont  = 6'(ext);
            b     = model_rf[word[3:0]];
        end else if (op != 0 && basic_code(op)) begin
            legal = 1'b1;
            cont  = 6'(op);
            if (op <= 3 || imm < 128) b = 16'(imm);
            else                      b = 16'(imm - 256);
        end else if (op == 8 && ext == 4) begin
            legal = 1'b1;
            cont  = 6'd37;
            b     = model_rf[word[3:0]];
        end else if (op == 8 && ext <= 1) begin
            legal = 1'b1;
            cont  = 6'd37;
            sh5   = ext * 16 + int'(word[3:0]);
            if (sh5 >= 16) sh5 = sh5 - 32;
            b     = 16'(sh5);
        end else if (op == 15) begin
            legal = 1'b1;
            cont  = 6'd63;
            b     = 16'(imm);
        end
        wr = legal && cont != 6'd11;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset          = 1'b1;
        bus.inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one word and follow it through EXEC, WB and the following IDLE
    task automatic applyStimulus(input string tag, input logic [15:0] word,
                                 input logic [5:0] e_cont, input logic [15:0] e_a,
                                 input logic [15:0] e_b, input logic e_ill,
                                 input logic [15:0] e_val);
        int n = 0;
        @(negedge clk);
        bus.inst       = word;
        bus.inst_valid = 1'b1;
        while (!bus.inst_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) checkOutput({tag, "_ready_timeout"}, 32'(bus.inst_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.inst_valid = 1'b0;
        bus.inst       = 16'h0000;
        checkOutput({tag, "_exec_ready"},  32'(bus.inst_ready), 32'd0);
        checkOutput({tag, "_exec_retire"}, 32'(bus.retire),     32'd0);
        checkOutput({tag, "_exec_cont"},   32'(bus.alu_cont),   32'(e_cont));
        checkOutput({tag, "_exec_a"},      32'(bus.alu_a),      32'(e_a));
        checkOutput({tag, "_exec_b"},      32'(bus.alu_b),      32'(e_b));
        @(posedge clk);
        #1;
        checkOutput({tag, "_wb_retire"},  32'(bus.retire),   32'd1);
        checkOutput({tag, "_wb_illegal"}, 32'(bus.illegal),  32'(e_ill));
        checkOutput({tag, "_wb_cont"},    32'(bus.alu_cont), 32'(e_cont));
        checkOutput({tag, "_wb_b"},       32'(bus.alu_b),    32'(e_b));
        @(posedge clk);
        #1;
        bus.dbg_addr = word[11:8];
        #1;
        checkOutput({tag, "_idle_ready"},  32'(bus.inst_ready), 32'd1);
        checkOutput({tag, "_idle_retire"}, 32'(bus.retire),     32'd0);
        checkOutput({tag, "_rd_value"},    32'(bus.dbg_data),   32'(e_val));
    endtask

    task automatic check_all_regs(input string tag);
        for (int r = 0; r < 16; r++) begin
            bus.dbg_addr = 4'(r);
            #1;
            checkOutput($sformatf("%s_r%0d", tag, r), 32'(bus.dbg_data), 32'(model_rf[r]));
        end
    endtask

    vec_t vecs [6];

    initial begin
        logic        legal;
        logic        wr;
        logic [5:0]  cont;
        logic [15:0] b;
        logic [15:0] a;
        logic [15:0] word;
        logic [15:0] result;
        int          ops [12];

        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.inst       = 16'h0000;
        bus.inst_valid = 1'b0;
        bus.dbg_addr   = 4'd0;
        for (int r = 0; r < 16; r++) model_rf[r] = 16'h0000;

        vecs[0] = '{"addi_r3",  16'h53FE, 6'b000101, 16'h0000, 16'hFFFE, 1'b0, 16'hFFFE};
        vecs[1] = '{"mov_r1",   16'h01D3, 6'b001101, 16'h0000, 16'hFFFE, 1'b0, 16'hFFFE};
        vecs[2] = '{"lui_r2",   16'hF212, 6'b111111, 16'h0000, 16'h0012, 1'b0, 16'h1200};
        vecs[3] = '{"lshi_r2",  16'h821C, 6'b100101, 16'h1200, 16'hFFFC, 1'b0, 16'h0120};
        vecs[4] = '{"cmp_r1",   16'h01B3, 6'b001011, 16'hFFFE, 16'hFFFE, 1'b0, 16'hFFFE};
        vecs[5] = '{"illegal7", 16'h7000, 6'b000000, 16'h0000, 16'h0000, 1'b1, 16'h0000};

        // Reset state
        applyReset();
        #1;
        checkOutput("rst_ready",   32'(bus.inst_ready), 32'd1);
        checkOutput("rst_cont",    32'(bus.alu_cont),   32'd0);
        checkOutput("rst_a",       32'(bus.alu_a),      32'd0);
        checkOutput("rst_b",       32'(bus.alu_b),      32'd0);
        checkOutput("rst_retire",  32'(bus.retire),     32'd0);
        checkOutput("rst_illegal", 32'(bus.illegal),    32'd0);
        check_all_regs("rst");

        // Test-plan vectors
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].name, vecs[i].inst, vecs[i].cont, vecs[i].a,
                          vecs[i].b, vecs[i].ill, vecs[i].rd_after);
        end
        model_rf[1] = 16'hFFFE;
        model_rf[2] = 16'h0120;
        model_rf[3] = 16'hFFFE;
        check_all_regs("plan");

        // Valid held high: ready pattern 1,0,0 and one execution per accept
        applyReset();
        bus.inst_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.inst = (k % 3 == 0) ? 16'h5101 : 16'h5110;
            #1;
            checkOutput($sformatf("b2b_ready_%0d", k), 32'(bus.inst_ready),
                        32'((k % 3) == 0));
            if (k % 3 != 0) checkOutput($sformatf("b2b_b_%0d", k), 32'(bus.alu_b), 32'h0001);
            @(negedge clk);
        end
        bus.inst_valid = 1'b0;
        bus.dbg_addr   = 4'd1;
        #1;
        checkOutput("b2b_r1_count", 32'(bus.dbg_data), 32'h0003);
        checkOutput("b2b_idle_ready", 32'(bus.inst_ready), 32'd1);

        // Reset during EXEC drops the pending write
        @(negedge clk);
        bus.inst       = 16'h5105;
        bus.inst_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.inst_valid = 1'b0;
        checkOutput("mid_exec_state", 32'(bus.inst_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("mid_rst_ready",  32'(bus.inst_ready), 32'd1);
        checkOutput("mid_rst_retire", 32'(bus.retire),     32'd0);
        checkOutput("mid_rst_cont",   32'(bus.alu_cont),   32'd0);
        for (int r = 0; r < 16; r++) model_rf[r] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_all_regs("mid_rst");

        // Random instructions against the reference model
        ops = '{0, 0, 1, 2, 3, 5, 6, 9, 11, 13, 8, 15};
        for (int t = 0; t < 80; t++) begin
            word = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                word[15:12] = 4'(ops[$urandom_range(0, 11)]);
                if (word[15:12] == 4'd8 && $urandom_range(0, 1) == 1) word[7:5] = 3'b000;
            end
            ref_decode(word, legal, cont, b, wr);
            a      = model_rf[word[11:8]];
            result = wr ? alu_fn(a, b, cont) : a;
            applyStimulus($sformatf("rnd%0d_%h", t, word), word, cont, a, b, !legal, result);
            model_rf[word[11:8]] = result;
        end
        check_all_regs("rnd_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_rf.md
# decode_rf

Instruction decode and register-file stage feeding the 16-bit ALU. Accepts one instruction word over a valid/ready handshake and reads operands from a 16×16 register file. Drives the ALU's `a`, `b` and 6-bit `alu_cont` inputs and writes `alu_out` back to the destination register. Runs a three-state sequencer, so each instruction occupies three cycles.

## Interface

Parameters:
- `WIDTH`, 16, datapath and register width.
- `ALU_CONT_BITS`, 6, ALU control width: {category[1:0], op[3:0]}.
- `REG_ADDR_BITS`, 4, register-file address width (16 registers).

Ports:
- `clk`, input, 1: the single clock; all state updates on posedge.
- `reset`, input, 1: synchronous, active-high. Top level drives the ALU's active-low reset with `~reset`.
- `inst`, input, 16: instruction word.
- `inst_valid`, input, 1: `inst` is valid.
- `inst_ready`, output, 1: block can accept an instruction.
- `alu_a`, output, WIDTH: Rdest operand to ALU `a`.
- `alu_b`, output, WIDTH: Rsrc or extended immediate to ALU `b`.
- `alu_cont`, output, ALU_CONT_BITS: ALU operation select.
- `alu_out`, input, WIDTH: ALU result.
- `retire`, output, 1: one-cycle pulse when an instruction completes.
- `illegal`, output, 1: one-cycle pulse, same cycle as `retire`, for an undecodable word.
- `dbg_addr`, input, REG_ADDR_BITS: debug read address.
- `dbg_data`, output, WIDTH: combinational `RF[dbg_addr]`.

## Operation

- Fields: `op=inst[15:12]`, `rd=inst[11:8]`, `ext=inst[7:4]`, `rs=inst[3:0]`, `imm8=inst[7:0]`.
- `op=0000` (R-type): `alu_cont={00,ext}`; `alu_b=RF[rs]`. Legal `ext` values:
  - 0001 AND, 0010 OR, 0011 XOR
  - 0101 ADD, 0110 ADDU, 1001 SUB
  - 1011 CMP, 1101 MOV
- I-type, `op` one of 0001/0010/0011/0101/0110/1001/1011/1101: `alu_cont={00,op}`.
  - `imm8` is zero-extended for 0001/0010/0011.
  - `imm8` is sign-extended for all other I-type ops.
- `op=1000` (shift):
  - `ext=0100` is LSH: `alu_b=RF[rs]`.
  - `ext[3:1]=000` is LSHI: `alu_b` = sign-extend of the 5-bit value `{ext[0],rs}`.
  - Both use `alu_cont=100101`.
- `op=1111` is LUI: `alu_cont=111111`, `alu_b=zext(imm8)`.
- `alu_a=RF[rd]` for every legal instruction.
- Writeback: `RF[rd] <= alu_out` for every legal instruction except CMP/CMPI (flags only).
- Illegal is any other encoding. Illegal instructions drive `alu_cont=000000`, write nothing, and pulse `illegal`.
- r0 is an ordinary register; it is not hard-wired to zero.

## Timing

- States: IDLE, EXEC, WB.
  - IDLE: `inst_ready=1`. On `inst_valid&&inst_ready`, latch `inst` and go to EXEC. Otherwise stay.
  - EXEC: go to WB unconditionally. The ALU samples operands at the negedge inside EXEC.
  - WB: perform the RF write (if any) at the posedge ending WB. `retire` (and `illegal`) are high during WB. Go to IDLE.
- `alu_a`, `alu_b` and `alu_cont` come combinationally from the latched instruction and the RF. They must stay stable from EXEC entry through the end of WB, because the ALU re-evaluates at the WB negedge.
- Latency: accept edge t0 → RF updated at t2. The next accept is possible at t3, giving 1 instruction per 3 cycles.
- `inst_ready` is 0 in EXEC and WB; `inst` is ignored there regardless of `inst_valid`.
- Reset values:
  - state IDLE, `inst_ready=1` in the cycle after reset, latched instruction 16'h0000.
  - `alu_cont=0`, `alu_a=0`, `alu_b=0`, `retire=0`, `illegal=0`.
  - all 16 registers 0.
- Reset mid-operation takes priority over everything. A pending WB write is dropped, state returns to IDLE, and the RF is cleared.
- `dbg_data` reflects a write starting the cycle after the WB edge.

## Structure

- Shared package `bananachine_pkg` holds:
  - opcode/ext constants
  - `alu_cont` constants (AND 000001 … MOV 001101, LSH 100101, LUI 111111)
  - state enum {IDLE, EXEC, WB}
- Sub-module `regfile16` provides 16×WIDTH storage with two combinational read ports plus the debug read port, one synchronous write port, and synchronous clear on `reset`.
- Decoder logic and the sequencer live in `decode_rf`.

## Test plan

- After reset, issue `16'h53FE` (ADDI r3,#-2), then `16'h01D3` (MOV r1,r3) → `alu_cont` 000101 then 001101, `alu_b`=16'hFFFE on the first; r3=r1=16'hFFFE; each retires 3 cycles after accept.
- Issue `16'hF212` (LUI r2,#0x12), then `16'h821C` (LSHI r2,#-4) → `alu_b`=16'hFFFC, `alu_cont`=100101; r2 goes 16'h1200, then 16'h0120.
- With r1=r3=16'hFFFE, issue `16'h01B3` (CMP r1,r3) → `alu_cont`=001011; no RF change; `retire` pulses.
- Issue `16'h7000` → `illegal` and `retire` pulse together in WB, `alu_cont`=000000, all registers unchanged.
- Hold `inst_valid` high with back-to-back words → `inst_ready` toggles 1,0,0; no word is accepted in EXEC or WB; each word is executed exactly once.
- Assert `reset` during EXEC of `16'h5105` → no write to r1; IDLE and `inst_ready=1` the cycle after reset deasserts; all `dbg_data` reads return 0.
